// File: rtl/pc_sequencer_pkg.sv
// Shared types and defaults for the program-counter sequencer.
package pc_sequencer_pkg;

    localparam int unsigned D_DEF     = 9;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_e;

    // Reset contents of the relative-branch offset table (two's complement).
    localparam int OFS0 = -5;
    localparam int OFS1 = 20;
    localparam int OFS2 = -1;
    localparam int OFS3 = 0;

endpackage

// File: rtl/pc_sequencer_if.sv
// Decode/fetch-side signal bundle of the PC sequencer.
interface pc_sequencer_if
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned D     = D_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
);
    logic             start;
    logic [D-1:0]     start_addr;
    logic             stall;
    logic             branch_en;
    logic [1:0]       branch_sel;
    logic             done_in;
    logic             cfg_we;
    logic [1:0]       cfg_addr;
    logic [D-1:0]     cfg_data;
    logic [D-1:0]     pc;
    logic             running;
    logic             halted;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output start, start_addr, stall, branch_en, branch_sel, done_in,
               cfg_we, cfg_addr, cfg_data,
        input  pc, running, halted, instr_count
    );

    modport slave (
        input  start, start_addr, stall, branch_en, branch_sel, done_in,
               cfg_we, cfg_addr, cfg_data,
        output pc, running, halted, instr_count
    );
endinterface

// File: rtl/branch_offset_table.sv
// 4-entry writable table of relative branch offsets; combinational read of registered contents.
module branch_offset_table
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned D = D_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         we_i,
    input  logic [1:0]   waddr_i,
    input  logic [D-1:0] wdata_i,
    input  logic [1:0]   raddr_i,
    output logic [D-1:0] rdata_o
);
    logic [D-1:0] tbl_q [4];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tbl_q[0] <= D'(OFS0);
            tbl_q[1] <= D'(OFS1);
            tbl_q[2] <= D'(OFS2);
            tbl_q[3] <= D'(OFS3);
        end else if (we_i) begin
            tbl_q[waddr_i] <= wdata_i;
        end
    end

    // A same-cycle write is not forwarded: readers see the old value until the next edge.
    assign rdata_o = tbl_q[raddr_i];
endmodule

// File: rtl/pc_sequencer.sv
// PC register, run/halt FSM and saturating retire counter for the single-cycle core.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int unsigned D     = D_DEF,
    parameter int unsigned CNT_W = CNT_W_DEF
) (
    input  logic         clk,
    input  logic         reset_n,
    pc_sequencer_if.slave bus
);
    state_e           state_q, state_d;
    logic [D-1:0]     pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [D-1:0]     ofs;

    branch_offset_table #(.D(D)) u_table (
        .clk     (clk),
        .reset_n (reset_n),
        .we_i    (bus.cfg_we),
        .waddr_i (bus.cfg_addr),
        .wdata_i (bus.cfg_data),
        .raddr_i (bus.branch_sel),
        .rdata_o (ofs)
    );

    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE, HALT: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = bus.start_addr;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                // Stall freezes everything; otherwise the instruction retires.
                if (!bus.stall) begin
                    cnt_d = cnt_inc;
                    if (bus.done_in)
                        state_d = HALT;
                    else if (bus.branch_en)
                        pc_d = pc_q + ofs;
                    else
                        pc_d = pc_q + D'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.running     = (state_q == RUN);
    assign bus.halted      = (state_q == HALT);
    assign bus.instr_count = cnt_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Randomized and directed bench for pc_sequencer against a plain-arithmetic reference model.
module tb_pc_sequencer;
    localparam int MOD = 512;

    logic clk;
    logic reset_n;
    int   n_checks = 0;
    int   n_pass   = 0;

    // Reference model: integers and flags, offsets kept as signed ints.
    int m_pc, m_cnt, m_cnt2;
    bit m_run, m_halt, m_run2;
    int m_ofs[4];

    pc_sequencer_if #(.D(9), .CNT_W(16)) bus ();
    pc_sequencer_if #(.D(9), .CNT_W(4))  bus2 ();

    pc_sequencer #(.D(9), .CNT_W(16)) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    pc_sequencer #(.D(9), .CNT_W(4)) u_dut_sat (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int wrapd(input int v);
        return ((v % MOD) + MOD) % MOD;
    endfunction

    function automatic int to_signed(input int v);
        return (v >= MOD / 2) ? v - MOD : v;
    endfunction

    task automatic model_reset();
        m_pc = 0; m_cnt = 0; m_run = 0; m_halt = 0;
        m_cnt2 = 0; m_run2 = 0;
        m_ofs[0] = -5; m_ofs[1] = 20; m_ofs[2] = -1; m_ofs[3] = 0;
    endtask

    task automatic idle_inputs();
        bus.start = 0; bus.start_addr = '0; bus.stall = 0; bus.branch_en = 0;
        bus.branch_sel = '0; bus.done_in = 0; bus.cfg_we = 0; bus.cfg_addr = '0;
        bus.cfg_data = '0;
        bus2.start = 0; bus2.start_addr = '0; bus2.stall = 0; bus2.branch_en = 0;
        bus2.branch_sel = '0; bus2.done_in = 0; bus2.cfg_we = 0; bus2.cfg_addr = '0;
        bus2.cfg_data = '0;
    endtask

    // Advance the model with the currently driven inputs, then let the DUT take the edge.
    task automatic tick();
        if (m_run) begin
            if (!bus.stall) begin
                m_cnt = (m_cnt < 65535) ? m_cnt + 1 : m_cnt;
                if (bus.done_in) begin
                    m_run = 0; m_halt = 1;
                end else if (bus.branch_en) begin
                    m_pc = wrapd(m_pc + m_ofs[bus.branch_sel]);
                end else begin
                    m_pc = wrapd(m_pc + 1);
                end
            end
        end else if (bus.start) begin
            m_run = 1; m_halt = 0; m_pc = int'(bus.start_addr); m_cnt = 0;
        end
        if (bus.cfg_we) m_ofs[bus.cfg_addr] = to_signed(int'(bus.cfg_data));
        if (m_run2) m_cnt2 = (m_cnt2 < 15) ? m_cnt2 + 1 : m_cnt2;
        else if (bus2.start) begin m_run2 = 1; m_cnt2 = 0; end
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input int addr);
        idle_inputs();
        bus.done_in = 1;
        tick();
        idle_inputs();
        bus.start = 1; bus.start_addr = 9'(addr);
        tick();
        idle_inputs();
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        n_checks++; if (bus.pc !== 9'd0) $display("FAIL reset_pc got=%0d exp=0", bus.pc); else n_pass++;
        n_checks++; if (bus.running !== 1'b0) $display("FAIL reset_running got=%b exp=0", bus.running); else n_pass++;
        n_checks++; if (bus.halted !== 1'b0) $display("FAIL reset_halted got=%b exp=0", bus.halted); else n_pass++;
        n_checks++; if (bus.instr_count !== 16'd0) $display("FAIL reset_count got=%0d exp=0", bus.instr_count); else n_pass++;
        reset_n = 1;
    endtask

    task automatic test_start_plain();
        bus.start = 1; bus.start_addr = 9'd10;
        tick();
        idle_inputs();
        n_checks++; if (bus.running !== 1'b1) $display("FAIL start_running got=%b exp=1", bus.running); else n_pass++;
        n_checks++; if (bus.pc !== 9'(m_pc)) $display("FAIL start_pc got=%0d exp=%0d", bus.pc, m_pc); else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (bus.pc !== 9'(m_pc)) $display("FAIL plain_pc got=%0d exp=%0d", bus.pc, m_pc); else n_pass++;
        end
        n_checks++; if (bus.instr_count !== 16'(m_cnt)) $display("FAIL plain_count got=%0d exp=%0d", bus.instr_count, m_cnt); else n_pass++;
    endtask

    task automatic test_branches();
        restart(30);
        for (int s = 0; s < 4; s++) begin
            bus.branch_en = 1; bus.branch_sel = 2'(s);
            tick();
            n_checks++; if (bus.pc !== 9'(m_pc)) $display("FAIL branch_sel%0d_pc got=%0d exp=%0d", s, bus.pc, m_pc); else n_pass++;
            n_checks++; if (bus.instr_count !== 16'(m_cnt)) $display("FAIL branch_sel%0d_count got=%0d exp=%0d", s, bus.instr_count, m_cnt); else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_wrap();
        restart(511);
        tick();
        n_checks++; if (bus.pc !== 9'(m_pc)) $display("FAIL wrap_plain got=%0d exp=%0d", bus.pc, m_pc); else n_pass++;
        restart(2);
        bus.branch_en = 1; bus.branch_sel = 2'd0;
        tick();
        idle_inputs();
        n_checks++; if (bus.pc !== 9'(m_pc)) $display("FAIL wrap_branch got=%0d exp=%0d", bus.pc, m_pc); else n_pass++;
    endtask

    task automatic test_priority();
        restart(40);
        bus.stall = 1; bus.branch_en = 1; bus.done_in = 1;
        tick();
        n_checks++; if (bus.pc !== 9'(m_pc) || bus.instr_count !== 16'(m_cnt) || bus.running !== 1'b1)
            $display("FAIL stall_hold got pc=%0d cnt=%0d run=%b exp pc=%0d cnt=%0d run=1",
                     bus.pc, bus.instr_count, bus.running, m_pc, m_cnt);
        else n_pass++;
        bus.stall = 0;
        tick();
        idle_inputs();
        n_checks++; if (bus.halted !== 1'b1 || bus.running !== 1'b0) $display("FAIL done_halt got halted=%b running=%b exp 1/0", bus.halted, bus.running); else n_pass++;
        n_checks++; if (bus.pc !== 9'(m_pc) || bus.instr_count !== 16'(m_cnt))
            $display("FAIL done_pc_cnt got pc=%0d cnt=%0d exp pc=%0d cnt=%0d", bus.pc, bus.instr_count, m_pc, m_cnt);
        else n_pass++;
        bus.start = 1; bus.start_addr = 9'd100;
        tick();
        idle_inputs();
        n_checks++; if (bus.pc !== 9'd100 || bus.instr_count !== 16'd0 || bus.running !== 1'b1)
            $display("FAIL halt_restart got pc=%0d cnt=%0d run=%b exp pc=100 cnt=0 run=1", bus.pc, bus.instr_count, bus.running);
        else n_pass++;
    endtask

    task automatic test_cfg_write();
        restart(50);
        bus.branch_en = 1; bus.branch_sel = 2'd1;
        bus.cfg_we = 1; bus.cfg_addr = 2'd1; bus.cfg_data = 9'd7;
        tick();
        bus.cfg_we = 0;
        n_checks++; if (bus.pc !== 9'(m_pc)) $display("FAIL cfg_old_value got=%0d exp=%0d", bus.pc, m_pc); else n_pass++;
        tick();
        idle_inputs();
        n_checks++; if (bus.pc !== 9'(m_pc)) $display("FAIL cfg_new_value got=%0d exp=%0d", bus.pc, m_pc); else n_pass++;
    endtask

    task automatic test_reset_mid_run();
        restart(200);
        tick();
        #2;
        reset_n = 0;
        model_reset();
        #1;
        n_checks++; if (bus.pc !== 9'd0 || bus.running !== 1'b0)
            $display("FAIL async_reset got pc=%0d run=%b exp pc=0 run=0", bus.pc, bus.running);
        else n_pass++;
        @(negedge clk);
        reset_n = 1;
        @(posedge clk);
        #1;
        bus.start = 1; bus.start_addr = 9'd0;
        tick();
        idle_inputs();
        bus.branch_en = 1; bus.branch_sel = 2'd1;
        tick();
        idle_inputs();
        n_checks++; if (bus.pc !== 9'(m_pc)) $display("FAIL reset_table_default got=%0d exp=%0d", bus.pc, m_pc); else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            bus.stall      = ($urandom_range(0, 4) == 0);
            bus.done_in    = ($urandom_range(0, 15) == 0);
            bus.branch_en  = $urandom_range(0, 1);
            bus.branch_sel = 2'($urandom_range(0, 3));
            bus.start      = $urandom_range(0, 1);
            bus.start_addr = 9'($urandom_range(0, 511));
            bus.cfg_we     = ($urandom_range(0, 5) == 0);
            bus.cfg_addr   = 2'($urandom_range(0, 3));
            bus.cfg_data   = 9'($urandom_range(0, 511));
            tick();
            n_checks++;
            if (bus.pc !== 9'(m_pc) || bus.instr_count !== 16'(m_cnt) ||
                bus.running !== m_run || bus.halted !== m_halt)
                $display("FAIL random_%0d got pc=%0d cnt=%0d run=%b halt=%b exp pc=%0d cnt=%0d run=%b halt=%b",
                         i, bus.pc, bus.instr_count, bus.running, bus.halted, m_pc, m_cnt, m_run, m_halt);
            else n_pass++;
        end
        idle_inputs();
    endtask

    task automatic test_saturation();
        bus2.start = 1; bus2.start_addr = 9'd3;
        tick();
        bus2.start = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 14 || i == 19) begin
                n_checks++;
                if (bus2.instr_count !== 4'(m_cnt2))
                    $display("FAIL saturate_%0d got=%0d exp=%0d", i, bus2.instr_count, m_cnt2);
                else n_pass++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_start_plain();
        test_branches();
        test_wrap();
        test_priority();
        test_cfg_write();
        test_reset_mid_run();
        test_random();
        test_saturation();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Program-counter sequencer for the single-cycle core. It owns the PC register and the run/halt state machine. It also owns a small writable table of relative branch offsets, which replaces a fixed offset lookup. Fetch reads pc; decode supplies stall, branch, and done indications.

Parameters:
D, 9, PC width in bits; all PC arithmetic is modulo 2^D.
CNT_W, 16, width of the retired-instruction counter.

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  launch execution; sampled only in IDLE or HALT
start_addr  in  D  first PC value loaded on start
stall  in  1  hold PC this cycle; no retire
branch_en  in  1  take a relative branch this cycle
branch_sel  in  2  offset-table index for the branch
done_in  in  1  current instruction is the halt instruction
cfg_we  in  1  offset-table write enable
cfg_addr  in  2  offset-table write index
cfg_data  in  D  offset value, two's complement, D bits
pc  out  D  current program counter
running  out  1  high in RUN
halted  out  1  high in HALT
instr_count  out  CNT_W  retired-instruction count, saturating

Behaviour:
- Single clock. Reset is asynchronous and active-low (reset_n); all state clears immediately on assertion.
- Reset values:
  - state = IDLE, pc = 0, running = 0, halted = 0, instr_count = 0.
  - Offset table = {0: -5 (all-ones pattern ...1011), 1: +20, 2: -1 (all ones), 3: 0}.
- States: IDLE, RUN, HALT. Outputs are registered; running = (state==RUN) and halted = (state==HALT).
- IDLE:
  - pc holds.
  - start=1 -> next cycle state = RUN, pc = start_addr, instr_count = 0.
- RUN, evaluated each rising edge in priority order:
  1. stall=1: pc, count, and state hold; branch_en and done_in are ignored.
  2. done_in=1: state -> HALT, pc holds, instr_count += 1. The halt instruction counts as retired.
  3. branch_en=1: pc = (pc + table[branch_sel]) mod 2^D, instr_count += 1.
  4. Otherwise: pc = (pc + 1) mod 2^D, instr_count += 1.
  - start is ignored in RUN.
- HALT:
  - pc and count hold.
  - start=1 -> RUN with pc = start_addr and instr_count = 0 on the next cycle.
- Arithmetic:
  - Plain D-bit add with carry out discarded. Wrap-around is required, e.g. pc=0 plus -1 gives 2^D-1.
  - Offset 0 means branch-to-self (spin); instr_count still increments.
- instr_count saturates at 2^CNT_W-1; it never wraps.
- Offset table:
  - cfg_we writes table[cfg_addr] = cfg_data at the clock edge. Writes are accepted in every state.
  - Read is combinational from registered contents, so a branch in the same cycle as a write to the same index uses the OLD value; the new value applies from the next cycle.
- Reset mid-RUN returns to IDLE, pc = 0, and table defaults; no partial update survives.
- Inputs other than start, start_addr, and cfg_* are don't-care outside RUN.

Decomposition:
- Package pc_sequencer_pkg:
  - state enum {IDLE, RUN, HALT}
  - default D and CNT_W
  - default offset constants OFS0=-5, OFS1=20, OFS2=-1, OFS3=0
- Sub-module branch_offset_table:
  - 4 x D register file with async active-low reset to the package defaults
  - one write port, one combinational read port
- pc_sequencer instantiates branch_offset_table and holds the FSM, PC register, and counter.

Test Plan:
- Reset released, start=1, start_addr=10 -> next cycle running=1, pc=10; three plain cycles -> pc=11,12,13, instr_count=3.
- Branches from pc=30:
  - branch_en=1, sel=0 -> pc=25.
  - From pc=25, sel=1 -> pc=45.
  - sel=2 -> pc=44.
  - sel=3 -> pc=44 (spin) and instr_count still increments.
- Wrap-around (D=9):
  - pc=511, plain step -> pc=0.
  - pc=2 with sel=0 (-5) -> pc=509.
- Priority:
  - stall=1 with branch_en=1 and done_in=1 -> pc and count unchanged, state RUN.
  - Next cycle done_in=1 and branch_en=1 -> HALT, pc unchanged, count+1; start=1, start_addr=100 -> RUN, pc=100, count=0.
- Config write:
  - cfg_we=1, addr=1, data=7 concurrent with a sel=1 branch at pc=50 -> pc=70 (old +20).
  - Next sel=1 branch from pc=70 -> pc=77.
- Reset mid-RUN:
  - Assert reset_n=0 between edges -> pc=0, running=0 immediately.
  - Restart and branch sel=1 -> the +20 default offset is restored.
